mpf_pll_supervisor: RTL and testbench
=====================================

Name: mpf_pll_supervisor

Overview:
- Controls the MPF PLL from the refclk side. Drives the PLL reset pulse, synchronizes and qualifies the PLL locked output, and retries on lock timeout.
- Reports a clean ready/fail status to downstream reset logic.
- Sits between the platform reset and the mpf_pll instance. Its ready output gates release of all outclk-domain resets.

Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 100000: cycles to wait for lock per attempt, 1 ms at 100 MHz (>=1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before ready (>=1).
- MAX_RETRIES, 3: retries after the first attempt before fail (>=0, <=2^RETRY_W-1).
- RETRY_W, 2: width of retry_count.

Ports:
- refclk, input, 1: single clock, 100 MHz reference.
- rst, input, 1: synchronous, active-high reset.
- pll_locked, input, 1: raw PLL locked, asynchronous to refclk.
- relock_req, input, 1: single-cycle request to restart the lock sequence.
- pll_rst, output, 1: drives the PLL rst input.
- ready, output, 1: PLL locked and stable.
- fail, output, 1: all attempts exhausted.
- lost_lock, output, 1: one-cycle pulse when lock drops while ready.
- retry_count, output, RETRY_W: retries used in the current sequence.
- state_dbg, output, 3: encoded FSM state (RESET_PLL=0, WAIT_LOCK=1, STABLE=2, READY=3, FAIL=4).

Behaviour:
- Clocking and reset: single clock refclk; rst is synchronous, active-high. All flops update on the rising refclk edge only.
- Reset values: pll_rst=1, ready=0, fail=0, lost_lock=0, retry_count=0, state_dbg=0. Synchronizer flops=0, counter=0.
- Synchronizer: pll_locked passes through a 2-flop synchronizer; only locked_s (second flop) is used. An edge on pll_locked affects the FSM at the 3rd refclk edge after it.
- Counter: one shared cycle counter, width clog2(max(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)). It clears to 0 on every state change.
- Outputs: all registered and decoded from the state register.
  - pll_rst=1 in RESET_PLL and FAIL.
  - ready=1 only in READY.
  - fail=1 only in FAIL.
- RESET_PLL:
  - pll_rst=1.
  - When counter==RST_PULSE_CYCLES-1, go to WAIT_LOCK.
  - locked_s is ignored in this state.
- WAIT_LOCK:
  - If locked_s=1, go to STABLE.
  - Else, when counter==LOCK_TIMEOUT_CYCLES-1:
    - if retry_count==MAX_RETRIES, go to FAIL;
    - otherwise increment retry_count and go to RESET_PLL.
- STABLE:
  - If locked_s=0, return to WAIT_LOCK. This is a glitch: retry_count is unchanged and the timeout restarts from 0.
  - When locked_s=1 and counter==LOCK_STABLE_CYCLES-1, go to READY.
- READY:
  - If locked_s=0: go to RESET_PLL, pulse lost_lock for exactly one cycle (the cycle ready first reads 0), and clear retry_count to 0.
- FAIL:
  - Terminal state. Exits only via rst or relock_req.
- relock_req, from any state:
  - Go to RESET_PLL, clear retry_count to 0 and the counter to 0.
  - No lost_lock pulse.
  - Priority: relock_req wins over any simultaneous locked_s change or counter terminal condition.
- Priority: rst beats relock_req, which beats locked_s or timeout events.
- Mid-operation rst: from any state, return to RESET_PLL next cycle with the reset values above. The pll_rst pulse restarts from 0.
- retry_count never wraps; it saturates at MAX_RETRIES by construction.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.

1. Normal lock: rst released, pll_locked rises 5 cycles after pll_rst falls.
   Required: pll_rst high for exactly 4 cycles after rst; state_dbg 1→2 on the 2nd edge after the first edge sampling pll_locked=1; ready=1 eight cycles later; retry_count=0; fail=0.
2. Lock timeout: pll_locked held 0.
   Required: three pll_rst pulses of 4 cycles, each followed by 20 WAIT_LOCK cycles; retry_count steps 0→1→2; then fail=1, pll_rst=1, state_dbg=4, held indefinitely.
3. Stability glitch: pll_locked drops for 1 cycle while the STABLE counter=5.
   Required: state returns to 1 then 2; stable count restarts from 0; ready asserts 8 STABLE cycles after re-entry; retry_count unchanged; lost_lock never pulses.
4. Loss in READY: pll_locked falls while ready=1.
   Required: ready=0 and lost_lock=1 for exactly one cycle, 3 edges after the fall; pll_rst=1 for 4 cycles; retry_count=0; normal relock follows.
5. Recovery from FAIL: assert relock_req for 1 cycle in FAIL.
   Required: next cycle fail=0, state_dbg=0, retry_count=0; a good pll_locked then yields ready=1 as in scenario 1.
6. Mid-operation reset: rst for 1 cycle during WAIT_LOCK with retry_count=1.
   Required: next cycle all reset values; a full 4-cycle pll_rst pulse; relock_req asserted in the same cycle as rst has no extra effect.

Source files
------------

// File: rtl/mpf_pll_supervisor.sv
// PLL reset sequencer: pulses pll_rst, qualifies a synchronized lock,
// retries on lock timeout and reports ready/fail to downstream resets.
module mpf_pll_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int RETRY_W             = 2
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               ready,
    output logic               fail,
    output logic               lost_lock,
    output logic [RETRY_W-1:0] retry_count,
    output logic [2:0]         state_dbg
);

    localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES)
                          ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_C  = (MAX_AB > LOCK_STABLE_CYCLES)
                          ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_READY     = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_d;
    logic               lost_d;
    logic               cnt_adv;
    logic               sync1_q;
    logic               locked_s;

    // Two-flop synchronizer for the asynchronous PLL lock flag
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1_q  <= pll_locked;
            locked_s <= sync1_q;
        end
    end

    // State, counter, retry and registered status outputs
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            lost_lock <= 1'b0;
            pll_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            lost_lock <= lost_d;
            pll_rst   <= (state_d == S_RESET_PLL) ||
                         (state_d == S_FAIL);
            ready     <= (state_d == S_READY);
            fail      <= (state_d == S_FAIL);
        end
    end

    // Next-state logic; relock_req overrides every in-state event
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = 1'b0;
        cnt_adv = 1'b0;
        if (relock_req) begin
            state_d = S_RESET_PLL;
            retry_d = '0;
        end else begin
            unique case (state_q)
                S_RESET_PLL: begin
                    cnt_adv = 1'b1;
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    cnt_adv = 1'b1;
                    if (locked_s) begin
                        state_d = S_STABLE;
                    end else if (cnt_q == TO_LAST) begin
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            retry_d = retry_q + RETRY_W'(1);
                            state_d = S_RESET_PLL;
                        end
                    end
                end
                S_STABLE: begin
                    cnt_adv = 1'b1;
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (cnt_q == STB_LAST) begin
                        state_d = S_READY;
                    end
                end
                S_READY: begin
                    if (!locked_s) begin
                        state_d = S_RESET_PLL;
                        retry_d = '0;
                        lost_d  = 1'b1;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_RESET_PLL;
                    retry_d = '0;
                end
            endcase
        end
    end

    // Shared cycle counter restarts on every state change or relock
    always_comb begin
        cnt_d = cnt_q;
        if (relock_req || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (cnt_adv) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign retry_count = retry_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mpf_pll_supervisor.sv
// Directed bench for mpf_pll_supervisor with small timing parameters.
// Inputs are driven and outputs sampled on the falling refclk edge.
module tb_mpf_pll_supervisor;

    localparam int RW = 2;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          relock_req = 1'b0;
    logic          pll_rst;
    logic          ready;
    logic          fail;
    logic          lost_lock;
    logic [RW-1:0] retry_count;
    logic [2:0]    state_dbg;

    int checks = 0;
    int errors = 0;
    int lost_cnt = 0;
    int n;

    mpf_pll_supervisor #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2),
        .RETRY_W             (RW)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_rst     (pll_rst),
        .ready       (ready),
        .fail        (fail),
        .lost_lock   (lost_lock),
        .retry_count (retry_count),
        .state_dbg   (state_dbg)
    );

    always #5 refclk = ~refclk;

    // Tally every cycle in which lost_lock is high
    always @(negedge refclk) begin
        if (lost_lock === 1'b1) lost_cnt++;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int k);
        repeat (k) @(negedge refclk);
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Count consecutive cycles with pll_rst high (use_rst) or in state st
    task automatic run_len(input bit use_rst,
                           input logic [2:0] st,
                           output int len);
        len = 0;
        while (len < 200 &&
               (use_rst ? (pll_rst === 1'b1) : (state_dbg === st))) begin
            len++;
            tick(1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_fail"}, 32'(fail), 32'd0);
        check({tag, "_lost"}, 32'(lost_lock), 32'd0);
        check({tag, "_retry"}, 32'(retry_count), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    // From WAIT_LOCK with pll_locked low: raise lock, follow it to READY
    task automatic lock_and_check(input string tag);
        pll_locked = 1'b1;
        tick(2);
        check({tag, "_still_wait"}, 32'(state_dbg), 32'd1);
        tick(1);
        check({tag, "_enter_stable"}, 32'(state_dbg), 32'd2);
        tick(7);
        check({tag, "_not_ready_yet"}, 32'(ready), 32'd0);
        tick(1);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_state_ready"}, 32'(state_dbg), 32'd3);
        check({tag, "_pll_rst_low"}, 32'(pll_rst), 32'd0);
    endtask

    initial begin
        tick(2);
        check_reset_vals("por");

        // Normal lock, pll_locked rises 5 cycles after pll_rst falls
        rst = 1'b0;
        run_len(1'b1, 3'd0, n);
        check("s1_rst_len", 32'(n), 32'd4);
        check("s1_state_wait", 32'(state_dbg), 32'd1);
        tick(5);
        lock_and_check("s1");
        check("s1_retry", 32'(retry_count), 32'd0);
        check("s1_fail", 32'(fail), 32'd0);

        // Lock lost while READY
        tick(1);
        pll_locked = 1'b0;
        tick(2);
        check("s4_ready_hold", 32'(ready), 32'd1);
        check("s4_lost_early", 32'(lost_lock), 32'd0);
        tick(1);
        check("s4_ready_drop", 32'(ready), 32'd0);
        check("s4_lost_pulse", 32'(lost_lock), 32'd1);
        check("s4_pll_rst", 32'(pll_rst), 32'd1);
        check("s4_state", 32'(state_dbg), 32'd0);
        check("s4_retry", 32'(retry_count), 32'd0);
        run_len(1'b1, 3'd0, n);
        check("s4_rst_len", 32'(n), 32'd4);
        check("s4_lost_clear", 32'(lost_lock), 32'd0);
        lock_and_check("s4");
        check("s4_lost_count", 32'(lost_cnt), 32'd1);

        // Stability glitch at STABLE counter 5
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check("s3_relock_state", 32'(state_dbg), 32'd0);
        check("s3_relock_nolost", 32'(lost_lock), 32'd0);
        tick(5);
        check("s3_stable", 32'(state_dbg), 32'd2);
        tick(3);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        check("s3_pre_glitch", 32'(state_dbg), 32'd2);
        tick(1);
        check("s3_back_wait", 32'(state_dbg), 32'd1);
        tick(1);
        check("s3_restable", 32'(state_dbg), 32'd2);
        check("s3_retry", 32'(retry_count), 32'd0);
        tick(7);
        check("s3_not_ready", 32'(ready), 32'd0);
        check("s3_still_stable", 32'(state_dbg), 32'd2);
        tick(1);
        check("s3_ready", 32'(ready), 32'd1);
        check("s3_lost_count", 32'(lost_cnt), 32'd1);

        // Lock timeout on every attempt
        pll_locked = 1'b0;
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check("s2_state", 32'(state_dbg), 32'd0);
        check("s2_nolost", 32'(lost_lock), 32'd0);
        for (int a = 0; a < 3; a++) begin
            run_len(1'b1, 3'd0, n);
            check($sformatf("s2_rst_len%0d", a), 32'(n), 32'd4);
            check($sformatf("s2_retry%0d", a), 32'(retry_count), 32'(a));
            run_len(1'b0, 3'd1, n);
            check($sformatf("s2_wait_len%0d", a), 32'(n), 32'd20);
        end
        check("s2_fail", 32'(fail), 32'd1);
        check("s2_fail_state", 32'(state_dbg), 32'd4);
        check("s2_fail_pll_rst", 32'(pll_rst), 32'd1);
        check("s2_fail_retry", 32'(retry_count), 32'd2);
        tick(30);
        check("s2_fail_hold", 32'(fail), 32'd1);
        check("s2_fail_state_hold", 32'(state_dbg), 32'd4);
        check("s2_fail_rst_hold", 32'(pll_rst), 32'd1);

        // Recovery from FAIL via relock_req
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check("s5_fail_clear", 32'(fail), 32'd0);
        check("s5_state", 32'(state_dbg), 32'd0);
        check("s5_retry", 32'(retry_count), 32'd0);
        run_len(1'b1, 3'd0, n);
        check("s5_rst_len", 32'(n), 32'd4);
        lock_and_check("s5");

        // Mid-operation reset during WAIT_LOCK with one retry used
        pll_locked = 1'b0;
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        run_len(1'b1, 3'd0, n);
        check("s6_rst_len0", 32'(n), 32'd4);
        run_len(1'b0, 3'd1, n);
        check("s6_wait_len0", 32'(n), 32'd20);
        run_len(1'b1, 3'd0, n);
        check("s6_rst_len1", 32'(n), 32'd4);
        check("s6_wait_state", 32'(state_dbg), 32'd1);
        check("s6_retry1", 32'(retry_count), 32'd1);
        tick(3);
        rst = 1'b1;
        relock_req = 1'b1;
        tick(1);
        rst = 1'b0;
        relock_req = 1'b0;
        check_reset_vals("s6");
        run_len(1'b1, 3'd0, n);
        check("s6_rst_len2", 32'(n), 32'd4);
        check("s6_after_state", 32'(state_dbg), 32'd1);
        check("s6_after_retry", 32'(retry_count), 32'd0);

        check("final_lost_count", 32'(lost_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
